// File: rtl/router_arbiter.sv
// router_arbiter: 5-port XY mesh router crossbar, per-output round-robin arbiters, registered outputs
module router_arbiter #(
  parameter int FW = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      x_id,
  input  logic [1:0]      y_id,
  input  logic [5*FW-1:0] in_data,
  input  logic [4:0]      in_valid,
  output logic [4:0]      in_ready,
  output logic [5*FW-1:0] out_data,
  output logic [4:0]      out_valid,
  input  logic [4:0]      out_ready
);
  logic [4:0][FW-1:0] flit, data_q, data_d;
  logic [4:0][2:0] ptr_q, ptr_d, route, gnt_idx;
  logic [4:0] valid_q, valid_d, gnt_vld, acc;

  function automatic logic [2:0] add5(input logic [2:0] p, input logic [2:0] k);
    logic [3:0] s;
    s = {1'b0, p} + {1'b0, k};
    return s >= 4'd5 ? 3'(s - 4'd5) : s[2:0];
  endfunction

  assign flit = in_data;
  assign out_data = data_q;
  assign out_valid = valid_q;

  // XY route: resolve X first, then Y, else deliver locally
  always_comb begin
    for (int i = 0; i < 5; i++)
      route[i] = flit[i][17:16] > x_id ? 3'd1 :
                 flit[i][17:16] < x_id ? 3'd0 :
                 flit[i][15:14] > y_id ? 3'd2 :
                 flit[i][15:14] < y_id ? 3'd3 : 3'd4;
  end

  // Round-robin grant per output; scanning backwards lets the candidate nearest the pointer win
  always_comb begin
    logic [2:0] c;
    c = '0;
    for (int j = 0; j < 5; j++) begin
      gnt_vld[j] = 1'b0;
      gnt_idx[j] = 3'd0;
      acc[j] = !valid_q[j] || out_ready[j];
      for (int k = 4; k >= 0; k--) begin
        c = add5(ptr_q[j], 3'(k));
        if (in_valid[c] && route[c] == 3'(j)) begin
          gnt_vld[j] = 1'b1;
          gnt_idx[j] = c;
        end
      end
    end
  end

  // An input is accepted only when it owns its routed output and that output has room
  always_comb begin
    for (int i = 0; i < 5; i++)
      in_ready[i] = rst && in_valid[i] && gnt_vld[route[i]] &&
                    gnt_idx[route[i]] == 3'(i) && acc[route[i]];
  end

  // Output register next state: drain, hold, or load (with hop rewrite on mesh ports)
  always_comb begin
    for (int j = 0; j < 5; j++) begin
      valid_d[j] = valid_q[j] && !out_ready[j];
      data_d[j] = data_q[j];
      ptr_d[j] = ptr_q[j];
      if (gnt_vld[j] && acc[j]) begin
        valid_d[j] = 1'b1;
        data_d[j] = j < 4 ? {flit[gnt_idx[j]][FW-1:14], x_id, y_id, flit[gnt_idx[j]][9:0]}
                          : flit[gnt_idx[j]];
        ptr_d[j] = add5(gnt_idx[j], 3'd1);
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      data_q <= '0;
      ptr_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_router_arbiter.sv
// tb_router_arbiter: directed vector table plus multi-cycle sequences for router_arbiter
module tb_router_arbiter;
  localparam int FW = 18;
  logic clk, rst;
  logic [1:0] x_id, y_id;
  logic [4:0][FW-1:0] in_data;
  logic [4:0] in_valid, in_ready, out_valid, out_ready;
  logic [5*FW-1:0] out_data;
  int errs = 0, checks = 0;

  router_arbiter #(.FW(FW)) dut (
    .clk(clk), .rst(rst), .x_id(x_id), .y_id(y_id),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] x, y;
    logic [4:0] iv;
    logic [4:0][FW-1:0] d;
    logic [4:0] rdy, ov;
    int p;
    logic [FW-1:0] f;
  } vec_t;

  function automatic logic [FW-1:0] fl(input int dx, dy, hx, hy, pl);
    return {2'(dx), 2'(dy), 2'(hx), 2'(hy), 10'(pl)};
  endfunction

  function automatic vec_t mk(input int x, y, input logic [4:0] iv,
                              input logic [FW-1:0] f0, f1, f2, f3, f4,
                              input logic [4:0] rdy, ov, input int p, input logic [FW-1:0] f);
    vec_t v;
    v.x = 2'(x); v.y = 2'(y); v.iv = iv; v.d = {f4, f3, f2, f1, f0};
    v.rdy = rdy; v.ov = ov; v.p = p; v.f = f;
    return v;
  endfunction

  function automatic logic [FW-1:0] outp(input int p);
    return out_data[p*FW +: FW];
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic rst_pulse(input int x, input int y);
    @(negedge clk);
    rst = 1'b0;
    in_valid = '0;
    x_id = 2'(x);
    y_id = 2'(y);
    #1 rst = 1'b1;
  endtask

  vec_t v[11];

  initial begin
    rst = 1'b0;
    x_id = 2'd1; y_id = 2'd1;
    in_valid = '1;
    out_ready = '1;
    for (int i = 0; i < 5; i++) in_data[i] = fl(3, 1, 0, 0, i);
    #3;
    chk("reset in_ready", 32'(in_ready), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_data", 32'(out_data[31:0] | out_data[89:58]), 32'h0);
    #4 rst = 1'b1;

    v[0]  = mk(1, 1, 5'b00001, fl(2,1,0,0,'h155), 0, 0, 0, 0, 5'b00001, 5'b00010, 1, fl(2,1,1,1,'h155));
    v[1]  = mk(1, 1, 5'b00100, 0, 0, fl(1,1,3,3,'h0AA), 0, 0, 5'b00100, 5'b10000, 4, fl(1,1,3,3,'h0AA));
    v[2]  = mk(1, 1, 5'b00001, fl(0,2,2,2,'h011), 0, 0, 0, 0, 5'b00001, 5'b00001, 0, fl(0,2,1,1,'h011));
    v[3]  = mk(1, 1, 5'b00010, 0, fl(1,3,0,0,'h022), 0, 0, 0, 5'b00010, 5'b00100, 2, fl(1,3,1,1,'h022));
    v[4]  = mk(1, 1, 5'b10000, 0, 0, 0, 0, fl(1,0,3,0,'h033), 5'b10000, 5'b01000, 3, fl(1,0,1,1,'h033));
    v[5]  = mk(1, 1, 5'b01001, fl(3,1,0,0,'h044), 0, 0, fl(3,1,0,0,'h055), 0, 5'b00001, 5'b00010, 1, fl(3,1,1,1,'h044));
    v[6]  = mk(1, 1, 5'b10010, 0, fl(0,0,0,0,'h066), 0, 0, fl(0,3,0,0,'h077), 5'b00010, 5'b00001, 0, fl(0,0,1,1,'h066));
    v[7]  = mk(1, 1, 5'b11111, fl(2,1,0,0,'h101), fl(0,1,0,0,'h102), fl(1,0,0,0,'h103), fl(1,2,0,0,'h104),
               fl(1,1,2,2,'h105), 5'b11111, 5'b11111, 3, fl(1,0,1,1,'h103));
    v[8]  = mk(1, 1, 5'b00000, fl(2,1,0,0,'h3FF), fl(0,1,0,0,'h3FF), fl(1,1,0,0,'h3FF), fl(1,0,0,0,'h3FF),
               fl(1,2,0,0,'h3FF), 5'b00000, 5'b00000, 1, 0);
    v[9]  = mk(3, 0, 5'b00011, fl(3,0,1,2,'h1AB), fl(2,0,0,0,'h1CD), 0, 0, 0, 5'b00011, 5'b10001, 4, fl(3,0,1,2,'h1AB));
    v[10] = mk(0, 3, 5'b10000, 0, 0, 0, 0, fl(0,2,1,1,'h2EE), 5'b10000, 5'b01000, 3, fl(0,2,0,3,'h2EE));

    for (int i = 0; i < 11; i++) begin
      rst_pulse(v[i].x, v[i].y);
      out_ready = '1;
      in_data = v[i].d;
      in_valid = v[i].iv;
      #1 chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(v[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(v[i].ov));
      chk($sformatf("vec%0d out_data", i), 32'(outp(v[i].p)), 32'(v[i].f));
      in_valid = '0;
    end

    // contention on E, pointer advance, wrap from 4 to 0
    rst_pulse(1, 1);
    in_data = '0;
    in_data[0] = fl(3,1,0,0,'h0A1);
    in_data[3] = fl(3,1,0,0,'h0A3);
    in_valid = 5'b01001;
    #1 chk("cont first grant", 32'(in_ready), 32'b00001);
    @(posedge clk); #1;
    chk("cont E carries W", 32'(outp(1)), 32'(fl(3,1,1,1,'h0A1)));
    in_valid = 5'b01000;
    #1 chk("cont second grant", 32'(in_ready), 32'b01000);
    @(posedge clk); #1;
    chk("cont E carries S", 32'(outp(1)), 32'(fl(3,1,1,1,'h0A3)));
    in_data[0] = fl(3,1,0,0,'h0B0);
    in_data[4] = fl(2,2,0,0,'h0B4);
    in_valid = 5'b10001;
    #1 chk("cont ptr4 picks L", 32'(in_ready), 32'b10000);
    @(posedge clk); #1;
    chk("cont E carries L", 32'(outp(1)), 32'(fl(2,2,1,1,'h0B4)));
    in_valid = 5'b00001;
    #1 chk("cont ptr wraps to W", 32'(in_ready), 32'b00001);
    @(posedge clk); #1;
    in_valid = '0;

    // backpressure on E while L keeps flowing
    rst_pulse(1, 1);
    out_ready = 5'b11101;
    in_data = '0;
    in_data[0] = fl(2,1,0,0,'h0C0);
    in_valid = 5'b00001;
    #1 chk("bp fill", 32'(in_ready), 32'b00001);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      in_data[0] = fl(2,1,0,0,'h0D0 + c);
      in_data[2] = fl(1,1,0,0,'h0E0 + c);
      in_valid = 5'b00101;
      #1 chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'b00100);
      @(posedge clk); #1;
      chk($sformatf("bp%0d E hold", c), 32'(outp(1)), 32'(fl(2,1,1,1,'h0C0)));
      chk($sformatf("bp%0d E valid", c), 32'(out_valid[1]), 32'd1);
      chk($sformatf("bp%0d L flit", c), 32'(outp(4)), 32'(fl(1,1,0,0,'h0E0 + c)));
    end
    out_ready = '1;
    in_data[0] = fl(2,1,0,0,'h0F0);
    in_valid = 5'b00001;
    #1 chk("bp refill ready", 32'(in_ready), 32'b00001);
    @(posedge clk); #1;
    chk("bp refill valid", 32'(out_valid[1]), 32'd1);
    chk("bp refill data", 32'(outp(1)), 32'(fl(2,1,1,1,'h0F0)));
    in_valid = '0;
    @(posedge clk); #1;
    chk("drain valid", 32'(out_valid), 32'h0);
    chk("drain keeps data", 32'(outp(1)), 32'(fl(2,1,1,1,'h0F0)));

    // full throughput, five transfers every cycle
    rst_pulse(1, 1);
    for (int c = 0; c < 3; c++) begin
      in_data[0] = fl(2,1,0,0,'h100 + c);
      in_data[1] = fl(0,1,0,0,'h200 + c);
      in_data[2] = fl(1,0,0,0,'h300 + c);
      in_data[3] = fl(1,2,0,0,'h010 + c);
      in_data[4] = fl(1,1,3,3,'h020 + c);
      in_valid = '1;
      #1 chk($sformatf("tp%0d in_ready", c), 32'(in_ready), 32'b11111);
      @(posedge clk); #1;
      chk($sformatf("tp%0d out_valid", c), 32'(out_valid), 32'b11111);
      chk($sformatf("tp%0d W out", c), 32'(outp(0)), 32'(fl(0,1,1,1,'h200 + c)));
      chk($sformatf("tp%0d L out", c), 32'(outp(4)), 32'(fl(1,1,3,3,'h020 + c)));
    end
    in_valid = '0;

    // asynchronous reset mid-burst
    rst_pulse(1, 1);
    in_data = '0;
    in_data[0] = fl(2,1,0,0,'h111);
    in_data[1] = fl(0,1,0,0,'h122);
    in_data[2] = fl(1,1,0,0,'h133);
    in_valid = 5'b00111;
    @(posedge clk); #1;
    chk("mid fill", 32'(out_valid), 32'b10011);
    out_ready = '0;
    in_data[0] = fl(3,1,0,0,'h144);
    in_data[3] = fl(3,1,0,0,'h155);
    in_valid = 5'b01001;
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'h0);
    chk("mid rst in_ready", 32'(in_ready), 32'h0);
    chk("mid rst out_data", 32'(outp(0) | outp(1) | outp(4)), 32'h0);
    rst = 1'b1;
    #1 chk("mid release tie", 32'(in_ready), 32'b00001);
    @(posedge clk); #1;
    chk("mid release valid", 32'(out_valid), 32'b00010);
    chk("mid release data", 32'(outp(1)), 32'(fl(3,1,1,1,'h144)));
    in_valid = '0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
